// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: width-generic conversions over a 32-bit carrier.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a narrower value are zero, so the MSB-down XOR chain stays correct.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] maxv(input int unsigned w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational Gray converter: i_dir=1 maps binary->Gray, i_dir=0 maps Gray->binary.
module gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val_c
);

  logic [MAX_WIDTH-1:0] w_wide;

  always_comb begin
    w_wide = MAX_WIDTH'(i_val);
    if (i_dir) begin
      o_val_c = WIDTH'(bin2gray(w_wide));
    end else begin
      o_val_c = WIDTH'(gray2bin(w_wide));
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Registered up/down Gray counter with binary/Gray parallel load, wrap or saturate.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter bit               WRAP      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             ld_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(maxv(WIDTH));
  localparam logic [WIDTH-1:0] RESET_GRY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VAL)));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ovf;

  logic [WIDTH-1:0] w_ld_bin;
  logic [WIDTH-1:0] w_nxt_bin;
  logic [WIDTH-1:0] w_nxt_gray;
  logic             w_nxt_ovf;
  logic             w_at_top;
  logic             w_at_bot;

  gray_conv #(.WIDTH(WIDTH)) u_load_conv (
    .i_dir   (1'b0),
    .i_val   (load_val),
    .o_val_c (w_ld_bin)
  );

  // Gray register is fed from the next binary value, so the pins never see decode glitches.
  gray_conv #(.WIDTH(WIDTH)) u_next_conv (
    .i_dir   (1'b1),
    .i_val   (w_nxt_bin),
    .o_val_c (w_nxt_gray)
  );

  assign w_at_top = (r_bin == MAXV);
  assign w_at_bot = (r_bin == '0);

  // Next state: load beats count beats hold.
  always_comb begin
    w_nxt_bin = r_bin;
    w_nxt_ovf = 1'b0;
    if (load) begin
      w_nxt_bin = ld_gray ? w_ld_bin : load_val;
    end else if (en) begin
      if (up) begin
        if (w_at_top) begin
          w_nxt_ovf = 1'b1;
          w_nxt_bin = WRAP ? '0 : r_bin;
        end else begin
          w_nxt_bin = r_bin + WIDTH'(1);
        end
      end else begin
        if (w_at_bot) begin
          w_nxt_ovf = 1'b1;
          w_nxt_bin = WRAP ? MAXV : r_bin;
        end else begin
          w_nxt_bin = r_bin - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= RESET_VAL;
      r_gray <= RESET_GRY;
      r_ovf  <= 1'b0;
    end else begin
      r_bin  <= w_nxt_bin;
      r_gray <= w_nxt_gray;
      r_ovf  <= w_nxt_ovf;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign ovf  = r_ovf;
  assign tc   = up ? w_at_top : w_at_bot;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: a wrapping and a saturating 4-bit instance on shared stimulus.
module tb_gray_counter_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic       ld_gray;
  logic [3:0] load_val;

  logic [3:0] bin_o  [2];
  logic [3:0] gray_o [2];
  logic       tc_o   [2];
  logic       ovf_o  [2];

  int n_cmp;
  int n_err;

  // index 0 wraps, index 1 saturates
  int m_bin   [2];
  bit m_ovf   [2];
  bit m_step  [2];
  int m_pgray [2];
  bit started;

  gray_counter_n #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_gray(ld_gray),
    .load_val(load_val), .bin(bin_o[0]), .gray(gray_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  gray_counter_n #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'd0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_gray(ld_gray),
    .load_val(load_val), .bin(bin_o[1]), .gray(gray_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int g_of(input int b);
    return b ^ (b / 2);
  endfunction

  // Gray -> binary as prefix XOR of all right shifts.
  function automatic int b_of_gray(input int g);
    int b;
    b = 0;
    for (int s = 0; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with out-of-range detection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_bin[i]   <= 0;
        m_ovf[i]   <= 1'b0;
        m_step[i]  <= 1'b0;
        m_pgray[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nb;
        m_pgray[i] <= g_of(m_bin[i]);
        m_step[i]  <= 1'b0;
        m_ovf[i]   <= 1'b0;
        if (load) begin
          m_bin[i] <= ld_gray ? b_of_gray(int'(load_val)) : int'(load_val);
        end else if (en) begin
          nb = m_bin[i] + (up ? 1 : -1);
          if (nb < 0 || nb > 15) begin
            m_ovf[i] <= 1'b1;
            if (i == 0) begin
              m_bin[i]  <= (nb + 16) % 16;
              m_step[i] <= 1'b1;
            end
          end else begin
            m_bin[i]  <= nb;
            m_step[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        check("bin",  i, 32'(bin_o[i]),  32'(m_bin[i]));
        check("gray", i, 32'(gray_o[i]), 32'(g_of(m_bin[i])));
        check("ovf",  i, 32'(ovf_o[i]),  32'(m_ovf[i]));
        check("tc",   i, 32'(tc_o[i]),   32'(up ? (m_bin[i] == 15) : (m_bin[i] == 0)));
        if (m_step[i]) begin
          check("hamming", i, 32'($countones(gray_o[i] ^ 4'(m_pgray[i]))), 32'd1);
        end
      end
    end
  end

  task automatic drive(input logic e, input logic u, input logic l, input logic g,
                       input logic [3:0] v);
    en = e; up = u; load = l; ld_gray = g; load_val = v;
    @(posedge clk);
    #1;
  endtask

  int gtab [16];

  initial begin
    gtab = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    n_cmp = 0; n_err = 0; started = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0; ld_gray = 1'b0; load_val = 4'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    started = 1'b1;
    check("rst_bin",  0, 32'(bin_o[0]),  32'h0);
    check("rst_gray", 0, 32'(gray_o[0]), 32'h0);
    check("rst_ovf",  0, 32'(ovf_o[0]),  32'h0);
    check("rst_tc",   0, 32'(tc_o[0]),   32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // count to 7, then reset asynchronously between edges
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("pre_rst_bin", 0, 32'(bin_o[0]), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bin",  0, 32'(bin_o[0]),  32'h0);
    check("mid_rst_gray", 0, 32'(gray_o[0]), 32'h0);
    check("mid_rst_bin",  1, 32'(bin_o[1]),  32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // full up cycle with wrap
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("seq_gray", 0, 32'(gray_o[0]), 32'(gtab[k % 16]));
      check("seq_ovf",  0, 32'(ovf_o[0]),  32'(k == 16));
    end

    // down wrap from zero
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("tc_bot", 0, 32'(tc_o[0]), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("dn_bin",  0, 32'(bin_o[0]),  32'hF);
    check("dn_gray", 0, 32'(gray_o[0]), 32'h8);
    check("dn_ovf",  0, 32'(ovf_o[0]),  32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("dn_ovf_clr", 0, 32'(ovf_o[0]), 32'h0);

    // Gray and binary loads
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
    check("ldg_bin",  0, 32'(bin_o[0]),  32'hC);
    check("ldg_gray", 1, 32'(gray_o[1]), 32'hA);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0101);
    check("ldb_bin",  1, 32'(bin_o[1]),  32'h5);
    check("ldb_gray", 0, 32'(gray_o[0]), 32'h7);

    // saturation at top
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("sat_bin",  1, 32'(bin_o[1]),  32'hF);
      check("sat_gray", 1, 32'(gray_o[1]), 32'h8);
      check("sat_ovf",  1, 32'(ovf_o[1]),  32'h1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("sat_ovf_clr", 1, 32'(ovf_o[1]), 32'h0);

    // load beats enable
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
    check("prio_bin", 0, 32'(bin_o[0]), 32'h3);
    check("prio_ovf", 0, 32'(ovf_o[0]), 32'h0);
    check("prio_bin", 1, 32'(bin_o[1]), 32'h3);

    // saturation at bottom, then direction flips
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("satlo_bin", 1, 32'(bin_o[1]), 32'h0);
    check("satlo_ovf", 1, 32'(ovf_o[1]), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("flip_bin", 1, 32'(bin_o[1]), 32'h2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
